key_mux_lock_bank: RTL

KEY_MUX_LOCK_BANK -- requirements
Module: key_mux_lock_bank

---
 rtl/key_mux_lock_bank.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/key_mux_lock_bank.sv
// key_mux_lock_bank
//
// A bank of NCH key-controlled 4:1 multiplexers. Each channel owns four
// bits of a secret key. The key is loaded serially, one bit per handshake,
// into a shadow register. It is only copied into the active key when exactly
// KW bits arrive and the last one is flagged with key_last. A malformed load
// wipes all key material and parks the bank in ERROR until zeroize or rst.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   key_start  - pulse to begin a serial key load (honoured in IDLE/ACTIVE)
//   key_valid  - key_bit/key_last valid this cycle
//   key_ready  - bank accepts a key bit this cycle (LOAD only)
//   key_bit    - serial key data, first accepted bit lands in key[0]
//   key_last   - marks the final key bit
//   zeroize    - wipe all key material and return to IDLE (highest priority)
//   sel_a      - per-channel select LSB
//   sel_b      - per-channel select MSB
//   sel_valid  - selects valid this cycle
//   y          - registered channel outputs, gated to 0 when not unlocked
//   y_valid    - y valid
//   unlocked   - an active key is committed
//   key_err    - the last load was malformed
module key_mux_lock_bank #(
    parameter int NCH = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_start,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic           key_bit,
    input  logic           key_last,
    input  logic           zeroize,
    input  logic [NCH-1:0] sel_a,
    input  logic [NCH-1:0] sel_b,
    input  logic           sel_valid,
    output logic [NCH-1:0] y,
    output logic           y_valid,
    output logic           unlocked,
    output logic           key_err
);

    localparam int KW = 4 * NCH;
    localparam int CW = $clog2(KW + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE,
        ERROR
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [KW-1:0]   r_shadow;
    logic [KW-1:0]   r_activeKey;
    logic [CW-1:0]   r_count;
    logic            r_unlocked;
    logic            r_keyErr;
    logic [NCH-1:0]  r_y;
    logic            r_yValid;

    logic            w_accept;
    logic [CW-1:0]   w_bitNum;
    logic            w_isFinalPos;
    logic [KW-1:0]   w_shadowNext;
    logic            w_commit;
    logic            w_fail;
    logic            w_idleStart;
    logic            w_rekeyStart;
    logic            w_outEnable;
    logic [NCH-1:0]  w_mux;

    // Handshake and load bookkeeping. w_bitNum is the 1-based number of the
    // bit being accepted this cycle, so the final position is w_bitNum == KW.
    // A load fails whenever key_last disagrees with being at the final position:
    // either key_last arrives early or the final bit arrives without it.
    assign w_accept     = key_valid && (r_state == LOAD);
    assign w_bitNum     = r_count + CW'(1);
    assign w_isFinalPos = (w_bitNum == CW'(KW));
    assign w_shadowNext = {key_bit, r_shadow[KW-1:1]};
    assign w_commit     = w_accept && !zeroize && key_last && w_isFinalPos;
    assign w_fail       = w_accept && !zeroize && (key_last != w_isFinalPos);
    assign w_idleStart  = key_start && !zeroize && (r_state == IDLE);
    assign w_rekeyStart = key_start && !zeroize && (r_state == ACTIVE);

    // Outputs are gated off on the very edge a rekey or zeroize begins, so the
    // outgoing key can never leak through once it is being replaced or wiped.
    assign w_outEnable  = sel_valid && r_unlocked && !zeroize && !w_rekeyStart;

    // Each channel picks one of its own four key bits; idx 00 is the lowest.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic [3:0] w_chanKey;
        logic [1:0] w_idx;
        assign w_chanKey = r_activeKey[4*gi +: 4];
        assign w_idx     = {sel_b[gi], sel_a[gi]};
        assign w_mux[gi] = w_chanKey[w_idx];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. zeroize overrides everything; key_start is only
    // honoured from IDLE or ACTIVE, and ERROR is sticky until zeroize/rst.
    always_comb begin
        w_nextState = r_state;
        if (zeroize) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (key_start) w_nextState = LOAD;
                LOAD: begin
                    if (w_commit)    w_nextState = ACTIVE;
                    else if (w_fail) w_nextState = ERROR;
                end
                ACTIVE:  if (key_start) w_nextState = LOAD;
                ERROR:   w_nextState = ERROR;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Output decode from state.
    always_comb begin
        key_ready = 1'b0;
        if (r_state == LOAD) begin
            key_ready = 1'b1;
        end
    end

    // Key material, bit counter and status flags. The shadow and counter are
    // cleared whenever a load starts so a fresh load never inherits bits from
    // an earlier attempt. On a failed load every copy of the key is wiped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_activeKey <= '0;
            r_count     <= '0;
            r_unlocked  <= 1'b0;
            r_keyErr    <= 1'b0;
        end else if (zeroize) begin
            r_shadow    <= '0;
            r_activeKey <= '0;
            r_count     <= '0;
            r_unlocked  <= 1'b0;
            r_keyErr    <= 1'b0;
        end else if (w_idleStart) begin
            r_shadow    <= '0;
            r_count     <= '0;
            r_keyErr    <= 1'b0;
        end else if (w_rekeyStart) begin
            r_shadow    <= '0;
            r_count     <= '0;
            r_unlocked  <= 1'b0;
        end else if (w_commit) begin
            r_shadow    <= w_shadowNext;
            r_activeKey <= w_shadowNext;
            r_count     <= w_bitNum;
            r_unlocked  <= 1'b1;
        end else if (w_fail) begin
            r_shadow    <= '0;
            r_activeKey <= '0;
            r_count     <= '0;
            r_unlocked  <= 1'b0;
            r_keyErr    <= 1'b1;
        end else if (w_accept) begin
            r_shadow    <= w_shadowNext;
            r_count     <= w_bitNum;
        end
    end

    // Registered mux outputs, one cycle after the selects are sampled.
    // Because r_unlocked is still 0 on the commit edge, selects sampled on
    // that edge produce nothing; the new key first shows one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y      <= '0;
            r_yValid <= 1'b0;
        end else if (w_outEnable) begin
            r_y      <= w_mux;
            r_yValid <= 1'b1;
        end else begin
            r_y      <= '0;
            r_yValid <= 1'b0;
        end
    end

    assign y        = r_y;
    assign y_valid  = r_yValid;
    assign unlocked = r_unlocked;
    assign key_err  = r_keyErr;

endmodule
